// File: rtl/psram_resp_pkg.sv
// Shared definitions for the octal-DDR PSRAM responder: command codes,
// mode-register count, FSM state and operation encodings, latency helper.
package psram_resp_pkg;

  localparam logic [7:0] CMD_MEM_RD = 8'h00;
  localparam logic [7:0] CMD_MEM_WR = 8'h80;
  localparam logic [7:0] CMD_REG_RD = 8'h40;
  localparam logic [7:0] CMD_REG_WR = 8'hC0;

  localparam int unsigned MR_COUNT    = 8;
  localparam logic [3:0]  MIN_LATENCY = 4'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_LAT,
    ST_WDATA,
    ST_RDATA,
    ST_REGW,
    ST_REGR,
    ST_DROP
  } state_t;

  typedef enum logic [1:0] {
    OP_MEM_RD,
    OP_MEM_WR,
    OP_REG_RD,
    OP_REG_WR
  } op_t;

  // Latency counter preload: 2 edges per SCK cycle, counted down to zero,
  // so the last latency edge is the one that sees zero.
  function automatic logic [4:0] lat_edges(input logic [3:0] mr0_lat);
    logic [3:0] eff;
    eff = (mr0_lat < MIN_LATENCY) ? MIN_LATENCY : mr0_lat;
    return {eff, 1'b0} - 5'd1;
  endfunction

endpackage

// File: rtl/psram_resp_sync.sv
// Two-flop synchroniser for the PSRAM pins plus SCK rise/fall detection.
// The CE stage resets to 0 (asserted) so the responder cannot treat a frame
// already in progress at reset release as a fresh one.
module psram_resp_sync
  import psram_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [7:0] io,
  input  logic       dqs,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       ce_n_s,
  output logic [7:0] io_s,
  output logic       dqs_s
);

  logic       sck_m;
  logic       sck_s;
  logic       sck_d;
  logic       ce_m;
  logic [7:0] io_m;
  logic       dqs_m;

  // Two-stage capture of all pins, plus one extra SCK stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_m  <= 1'b0;
      sck_s  <= 1'b0;
      sck_d  <= 1'b0;
      ce_m   <= 1'b0;
      ce_n_s <= 1'b0;
      io_m   <= '0;
      io_s   <= '0;
      dqs_m  <= 1'b0;
      dqs_s  <= 1'b0;
    end else begin
      sck_m  <= sck;
      sck_s  <= sck_m;
      sck_d  <= sck_s;
      ce_m   <= ce_n;
      ce_n_s <= ce_m;
      io_m   <= io;
      io_s   <= io_m;
      dqs_m  <= dqs;
      dqs_s  <= dqs_m;
    end
  end

  // Edge pulses are aligned with the synchronised data byte they carry.
  always_comb begin
    sck_rise = sck_s & ~sck_d;
    sck_fall = ~sck_s & sck_d;
  end

endmodule

// File: rtl/psram_resp.sv
// Octal-DDR PSRAM device responder: decodes command/address frames sampled
// in the clk_i domain, holds a byte array and eight mode registers, and
// returns read data with a source-synchronous DQS.
// Optional build macro PSRAM_RESP_WRAP32_EN: MR1[0] = 1 selects 32-byte
// aligned address wrap for memory reads/writes.
// ADDR_WIDTH must be at least 9 (address bytes are shifted into the counter).
module psram_resp
  import psram_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter logic [3:0]  DEF_LATENCY = 4'd5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_in_i,
  output logic [7:0] psram_io_out_o,
  output logic [7:0] psram_io_en_o,
  input  logic       psram_dqs_in_i,
  output logic       psram_dqs_out_o,
  output logic       psram_dqs_en_o,
  output logic       busy_o,
  output logic       cmd_err_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic       sck_rise;
  logic       sck_fall;
  logic       ce_n_s;
  logic [7:0] io_s;
  logic       dqs_s;
  logic       edge_any;

  state_t                state;
  op_t                   op;
  logic [1:0]            cnt;
  logic [4:0]            lat_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  armed;
  logic                  regw_done;
  logic [7:0]            mr [MR_COUNT];
  logic [7:0]            mem [2**ADDR_WIDTH];
  logic                  mem_we;

  psram_resp_sync u_sync (
    .clk      (clk_i),
    .rst      (rst_i),
    .sck      (psram_sck_i),
    .ce_n     (psram_ce_i),
    .io       (psram_io_in_i),
    .dqs      (psram_dqs_in_i),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ce_n_s   (ce_n_s),
    .io_s     (io_s),
    .dqs_s    (dqs_s)
  );

  // Any SCK transition carries one byte.
  always_comb begin
    edge_any = sck_rise | sck_fall;
  end

  // Next data address: linear by default, optional 32-byte block wrap.
  always_comb begin
    addr_next = addr + ADDR_ONE;
`ifdef PSRAM_RESP_WRAP32_EN
    if (mr[1][0]) begin
      addr_next = {addr[ADDR_WIDTH-1:5], addr[4:0] + 5'd1};
    end
`endif
  end

  // Write strobe for the byte array; CE release drops a coincident edge.
  always_comb begin
    mem_we = (state == ST_WDATA) && edge_any && !ce_n_s && !dqs_s;
  end

  // Byte array storage, never reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[addr] <= io_s;
    end
  end

  // Frame FSM with registered pin outputs, counters and mode registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      op              <= OP_MEM_RD;
      cnt             <= '0;
      lat_cnt         <= '0;
      addr            <= '0;
      armed           <= 1'b0;
      regw_done       <= 1'b0;
      psram_io_out_o  <= '0;
      psram_io_en_o   <= '0;
      psram_dqs_out_o <= 1'b0;
      psram_dqs_en_o  <= 1'b0;
      busy_o          <= 1'b0;
      cmd_err_o       <= 1'b0;
      mr[0]           <= {4'h0, DEF_LATENCY};
      for (int unsigned i = 1; i < MR_COUNT; i++) begin
        mr[i] <= '0;
      end
    end else begin
      cmd_err_o <= 1'b0;
      if (ce_n_s) begin
        // CE release aborts any frame and re-arms frame detection.
        state           <= ST_IDLE;
        armed           <= 1'b1;
        busy_o          <= 1'b0;
        psram_io_en_o   <= '0;
        psram_dqs_en_o  <= 1'b0;
        psram_dqs_out_o <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (armed) begin
              state  <= ST_CMD;
              busy_o <= 1'b1;
              cnt    <= '0;
            end
          end
          ST_CMD: begin
            if (edge_any) begin
              if (cnt == 2'd0) begin
                cnt <= 2'd1;
                unique case (io_s)
                  CMD_MEM_RD: op <= OP_MEM_RD;
                  CMD_MEM_WR: op <= OP_MEM_WR;
                  CMD_REG_RD: op <= OP_REG_RD;
                  CMD_REG_WR: op <= OP_REG_WR;
                  default: begin
                    state     <= ST_DROP;
                    cmd_err_o <= 1'b1;
                  end
                endcase
              end else begin
                cnt   <= '0;
                state <= ST_ADDR;
              end
            end
          end
          ST_ADDR: begin
            if (edge_any) begin
              // Shifting bytes in MSB-first leaves the low ADDR_WIDTH bits.
              addr <= {addr[ADDR_WIDTH-9:0], io_s};
              cnt  <= cnt + 2'd1;
              if (cnt == 2'd3) begin
                lat_cnt   <= lat_edges(mr[0][3:0]);
                regw_done <= 1'b0;
                state     <= (op == OP_REG_WR) ? ST_REGW : ST_LAT;
              end
            end
          end
          ST_LAT: begin
            if (edge_any) begin
              if (lat_cnt == 5'd0) begin
                unique case (op)
                  OP_MEM_WR: state <= ST_WDATA;
                  OP_REG_RD: state <= ST_REGR;
                  default:   state <= ST_RDATA;
                endcase
              end else begin
                lat_cnt <= lat_cnt - 5'd1;
              end
            end
          end
          ST_WDATA: begin
            if (edge_any) begin
              addr <= addr_next;
            end
          end
          ST_RDATA: begin
            if (edge_any) begin
              psram_io_out_o  <= mem[addr];
              psram_dqs_out_o <= sck_rise;
              psram_io_en_o   <= '1;
              psram_dqs_en_o  <= 1'b1;
              addr            <= addr_next;
            end
          end
          ST_REGW: begin
            if (edge_any && !regw_done) begin
              mr[addr[2:0]] <= io_s;
              regw_done     <= 1'b1;
            end
          end
          ST_REGR: begin
            if (edge_any) begin
              psram_io_out_o  <= mr[addr[2:0]];
              psram_dqs_out_o <= sck_rise;
              psram_io_en_o   <= '1;
              psram_dqs_en_o  <= 1'b1;
            end
          end
          ST_DROP: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psram_resp.sv
// Directed self-checking bench for psram_resp.
module tb_psram_resp;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       ce;
  logic [7:0] io;
  logic       dqs_in;
  logic [7:0] io_out;
  logic [7:0] io_en;
  logic       dqs_out;
  logic       dqs_en;
  logic       busy;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  logic [7:0] wbuf [8];
  logic [7:0] ebuf [8];

  psram_resp #(
    .ADDR_WIDTH  (16),
    .DEF_LATENCY (4'd5)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .psram_sck_i     (sck),
    .psram_ce_i      (ce),
    .psram_io_in_i   (io),
    .psram_io_out_o  (io_out),
    .psram_io_en_o   (io_en),
    .psram_dqs_in_i  (dqs_in),
    .psram_dqs_out_o (dqs_out),
    .psram_dqs_en_o  (dqs_en),
    .busy_o          (busy),
    .cmd_err_o       (cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_err === 1'b1) err_pulses++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sck_edge(input logic [7:0] d, input logic dm);
    io = d;
    dqs_in = dm;
    repeat (2) @(negedge clk);
    sck = ~sck;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_begin();
    ce = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end(input string tag);
    ce = 1'b1;
    io = '0;
    dqs_in = 1'b0;
    repeat (4) @(negedge clk);
    check_eq({tag, "_end_busy"}, busy, 0);
    check_eq({tag, "_end_io_en"}, io_en, 0);
    check_eq({tag, "_end_dqs_en"}, dqs_en, 0);
  endtask

  task automatic header(input logic [7:0] cmd, input logic [31:0] a);
    sck_edge(cmd, 1'b0);
    sck_edge(cmd, 1'b0);
    for (int i = 3; i >= 0; i--) sck_edge(a[i*8 +: 8], 1'b0);
  endtask

  task automatic latency(input int lat, input string tag);
    for (int i = 0; i < 2 * lat; i++) sck_edge(8'h00, 1'b0);
    check_eq({tag, "_lat_io_en"}, io_en, 0);
    check_eq({tag, "_lat_busy"}, busy, 1);
  endtask

  task automatic write_reg(input logic [2:0] ra, input logic [7:0] v);
    frame_begin();
    header(8'hC0, {29'd0, ra});
    sck_edge(v, 1'b0);
    sck_edge(8'hFF, 1'b0);
    check_eq("regw_io_en", io_en, 0);
    frame_end("regw");
  endtask

  task automatic read_reg(input logic [2:0] ra, input int lat, input logic [7:0] exp, input string tag);
    frame_begin();
    header(8'h40, {29'd0, ra});
    latency(lat, tag);
    for (int i = 0; i < 2; i++) begin
      sck_edge(8'h00, 1'b0);
      check_eq($sformatf("%s_data%0d", tag, i), io_out, exp);
      check_eq($sformatf("%s_dqs%0d", tag, i), dqs_out, sck);
      check_eq($sformatf("%s_en%0d", tag, i), {dqs_en, io_en}, 9'h1FF);
    end
    frame_end(tag);
  endtask

  task automatic write_mem(input logic [31:0] a, input int n, input logic [7:0] mask, input int lat, input string tag);
    frame_begin();
    header(8'h80, a);
    latency(lat, tag);
    for (int i = 0; i < n; i++) sck_edge(wbuf[i], mask[i]);
    check_eq({tag, "_wr_io_en"}, io_en, 0);
    frame_end(tag);
  endtask

  // First data edge also checks the 3 clk_i pin-to-output latency.
  task automatic read_mem(input logic [31:0] a, input int n, input int lat, input string tag);
    frame_begin();
    header(8'h00, a);
    latency(lat, tag);
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        io = '0;
        repeat (2) @(negedge clk);
        sck = ~sck;
        repeat (2) @(negedge clk);
        check_eq({tag, "_en_at_2clk"}, io_en, 8'h00);
        @(negedge clk);
        check_eq({tag, "_en_at_3clk"}, io_en, 8'hFF);
        @(negedge clk);
      end else begin
        sck_edge(8'h00, 1'b0);
      end
      check_eq($sformatf("%s_data%0d", tag, i), io_out, ebuf[i]);
      check_eq($sformatf("%s_dqs%0d", tag, i), dqs_out, sck);
      check_eq($sformatf("%s_dqs_en%0d", tag, i), dqs_en, 1);
    end
    frame_end(tag);
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b1;
    sck = 1'b0;
    io = '0;
    dqs_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_io_out", io_out, 0);
    check_eq("rst_io_en", io_en, 0);
    check_eq("rst_dqs", {dqs_out, dqs_en}, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cmd_err", cmd_err, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Default MR0 = 5 readback, then MR0 = 7 and 14 dummy edges.
    read_reg(3'd0, 5, 8'h05, "mr0_def");
    write_reg(3'd0, 8'h07);
    read_reg(3'd0, 7, 8'h07, "mr0_7");
    // MR0 below minimum: reads back as written, counts as 3.
    write_reg(3'd0, 8'h01);
    read_reg(3'd0, 3, 8'h01, "mr0_1");

    // Memory write/read of 8 bytes.
    wbuf = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    write_mem(32'h0000_0100, 8, 8'h00, 3, "w100");
    ebuf = wbuf;
    read_mem(32'h0000_0100, 8, 3, "r100");

    // Data mask over previously zeroed bytes.
    wbuf = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    write_mem(32'h0000_0200, 4, 8'h00, 3, "w200z");
    wbuf = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h00};
    write_mem(32'h0000_0200, 4, 8'b0000_1010, 3, "w200m");
    ebuf = '{8'hAA, 8'h00, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    read_mem(32'h0000_0200, 4, 3, "r200");

    // Linear wrap at top of array; upper frame address bits discarded.
    wbuf = '{8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    write_mem(32'h1234_FFFF, 2, 8'h00, 3, "wffff");
    ebuf = '{8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    read_mem(32'h0000_FFFF, 2, 3, "rffff");
    ebuf = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    read_mem(32'h0000_0000, 1, 3, "r0000");

    // 32-byte wrap mode (effective only with the build macro).
    wbuf = '{8'hB0, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    write_mem(32'h0000_0000, 2, 8'h00, 3, "w00");
    wbuf = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'h00, 8'h00, 8'h00};
    write_mem(32'h0000_001E, 4, 8'h00, 3, "w1e");
    write_reg(3'd1, 8'h01);
    read_reg(3'd1, 3, 8'h01, "mr1");
`ifdef PSRAM_RESP_WRAP32_EN
    ebuf = '{8'hC1, 8'hC2, 8'hB0, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    ebuf = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    read_mem(32'h0000_001E, 4, 3, "r1e");
    write_reg(3'd1, 8'h00);

    // Abort after 3 read-data edges (frame_end checks drop of enables/busy).
    ebuf = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    read_mem(32'h0000_0100, 3, 3, "abort");

    // Unknown command: one error pulse, no drive, frame ignored.
    check_eq("err_before", err_pulses, 0);
    frame_begin();
    for (int i = 0; i < 10; i++) sck_edge(8'h55, 1'b0);
    check_eq("drop_io_en", io_en, 0);
    check_eq("drop_dqs_en", dqs_en, 0);
    check_eq("drop_busy", busy, 1);
    check_eq("drop_err_pulses", err_pulses, 1);
    frame_end("drop");
    ebuf = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    read_mem(32'h0000_0100, 2, 3, "post_drop");
    check_eq("err_after", err_pulses, 1);

    // Reset mid-frame: stays idle until CE is seen high then low again.
    frame_begin();
    header(8'h00, 32'h0000_0100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("midrst_busy", busy, 0);
    for (int i = 0; i < 6; i++) sck_edge(8'h00, 1'b0);
    check_eq("midrst_idle_busy", busy, 0);
    check_eq("midrst_idle_en", io_en, 0);
    frame_end("midrst");
    read_mem(32'h0000_0100, 2, 5, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
